cam_map: RTL and testbench

- Programmable key→data map; successor to the static combinational LUT mux.
- Holds NR_KEY (key, data, valid) entries in registers.
- Entries are inserted, updated and deleted at run time through a write port.
- Lookups use a valid/ready handshake with registered output and a per-lookup default.
- Sits in front of decode/CSR/MMIO dispatch logic where the key→value table must change at run time.

---
 rtl/cam_map_pkg.sv | 38 +++
 rtl/cam_map_match.sv | 58 +++++
 rtl/cam_map.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_cam_map.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_map_pkg.sv
// ---------------------------------------------------------------------------
// cam_map_pkg
//
// Purpose:
//   Shared encodings for the programmable key->data map (cam_map) and its
//   match/priority-encode helper (cam_map_match).
//
// Contents:
//   wr_op_e   - write-port command encodings
//   state_e   - control FSM state encodings
//   STAT_MAX  - saturation value of the optional lookup statistics counters
//   satInc32  - saturating 32-bit increment used by the statistics counters
// ---------------------------------------------------------------------------
package cam_map_pkg;

    // Write-port command codes carried on wr_op.
    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_UPSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_CLEAR  = 2'b11
    } wr_op_e;

    // RUN serves lookups and single-cycle writes; CLEAR walks the table
    // invalidating one entry per cycle.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [31:0] satInc32(input logic [31:0] value);
        return (value == STAT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/cam_map_match.sv
// ---------------------------------------------------------------------------
// cam_map_match
//
// Purpose:
//   Combinational compare of one key against every entry of the map,
//   followed by a lowest-index-wins priority encoder.  With i_anyValid set the
//   key compare is bypassed and the encoder simply finds the lowest set bit
//   of i_valid, which is how the parent locates a free slot (by feeding in
//   the inverted valid vector).
//
// Parameters:
//   NR_KEY   - number of entries
//   KEY_LEN  - key width
//
// Ports:
//   i_key      in   KEY_LEN          key to compare
//   i_keys     in   NR_KEY x KEY_LEN stored keys
//   i_valid    in   NR_KEY           per-entry qualifier
//   i_anyValid in   1                ignore keys, match on i_valid alone
//   o_hit      out  1                at least one entry matched
//   o_idx      out  IDX_LEN          lowest matching index (0 when no hit)
// ---------------------------------------------------------------------------
module cam_map_match #(
    parameter  int NR_KEY  = 8,
    parameter  int KEY_LEN = 4,
    localparam int IDX_LEN = $clog2(NR_KEY)
) (
    input  logic [KEY_LEN-1:0]             i_key,
    input  logic [NR_KEY-1:0][KEY_LEN-1:0] i_keys,
    input  logic [NR_KEY-1:0]              i_valid,
    input  logic                           i_anyValid,
    output logic                           o_hit,
    output logic [IDX_LEN-1:0]             o_idx
);

    logic [NR_KEY-1:0] w_match;

    // Per-entry match vector: an entry only counts if its qualifier is set.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            w_match[i] = i_valid[i] & (i_anyValid | (i_keys[i] == i_key));
        end
    end

    // Priority encoder: scanning from the top down lets the lowest matching
    // index overwrite any higher one, so the lowest index wins.
    always_comb begin
        o_hit = |w_match;
        o_idx = '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_idx = IDX_LEN'(i);
            end
        end
    end

endmodule

// File: rtl/cam_map.sv
// ---------------------------------------------------------------------------
// cam_map
//
// Purpose:
//   Run-time programmable key->data map.  NR_KEY (key, data, valid) entries
//   live in registers.  A write port inserts/updates (UPSERT), removes
//   (DELETE) or wipes (CLEAR) entries; a valid/ready lookup port returns the
//   matching data, or a per-lookup default on a miss, through a one-entry
//   registered response stage.
//
// Parameters:
//   NR_KEY   - number of entries (>= 2)
//   KEY_LEN  - key width
//   DATA_LEN - data width
//
// Ports:
//   clk         in   1         clock
//   rst_n       in   1         synchronous active-low reset
//   lk_valid    in   1         lookup request
//   lk_ready    out  1         lookup accepted when lk_valid & lk_ready
//   lk_key      in   KEY_LEN   key to look up
//   lk_default  in   DATA_LEN  value returned on a miss
//   rsp_valid   out  1         lookup result valid
//   rsp_ready   in   1         consumer accepts result
//   rsp_data    out  DATA_LEN  hit data or captured default
//   rsp_hit     out  1         key matched a valid entry
//   rsp_idx     out  IDX_LEN   matching index (0 on miss)
//   wr_valid    in   1         write command
//   wr_ready    out  1         write accepted when wr_valid & wr_ready
//   wr_op       in   2         00 NOP, 01 UPSERT, 10 DELETE, 11 CLEAR
//   wr_key      in   KEY_LEN   command key
//   wr_data     in   DATA_LEN  command data (UPSERT only)
//   wr_done     out  1         one-cycle pulse the cycle after completion
//   wr_ok       out  1         command status, valid with wr_done
//   count       out  CNT_LEN   number of valid entries
//   full        out  1         count == NR_KEY
//   hit_cnt     out  32        (CAM_MAP_STATS_EN only) saturating hit count
//   miss_cnt    out  32        (CAM_MAP_STATS_EN only) saturating miss count
//
// Configuration:
//   CAM_MAP_STATS_EN - when defined, adds the hit_cnt/miss_cnt statistics
//                      ports and counters.
// ---------------------------------------------------------------------------
module cam_map
    import cam_map_pkg::*;
#(
    parameter  int NR_KEY   = 8,
    parameter  int KEY_LEN  = 4,
    parameter  int DATA_LEN = 8,
    localparam int IDX_LEN  = $clog2(NR_KEY),
    localparam int CNT_LEN  = $clog2(NR_KEY + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lk_valid,
    output logic                lk_ready,
    input  logic [KEY_LEN-1:0]  lk_key,
    input  logic [DATA_LEN-1:0] lk_default,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_LEN-1:0] rsp_data,
    output logic                rsp_hit,
    output logic [IDX_LEN-1:0]  rsp_idx,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [1:0]          wr_op,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    output logic                wr_done,
    output logic                wr_ok,
    output logic [CNT_LEN-1:0]  count,
    output logic                full
`ifdef CAM_MAP_STATS_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
`endif
);

    // ------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------
    state_e                          r_state;
    state_e                          w_stateNext;
    logic [IDX_LEN-1:0]              r_clrIdx;

    logic [NR_KEY-1:0]               r_valid;
    logic [NR_KEY-1:0][KEY_LEN-1:0]  r_keys;
    logic [NR_KEY-1:0][DATA_LEN-1:0] r_data;
    logic [CNT_LEN-1:0]              r_count;

    logic                            r_rspValid;
    logic                            r_rspHit;
    logic [IDX_LEN-1:0]              r_rspIdx;
    logic [DATA_LEN-1:0]             r_rspData;

    logic                            r_wrDone;
    logic                            r_wrOk;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                            w_lkHit;
    logic [IDX_LEN-1:0]              w_lkIdx;
    logic                            w_wrHit;
    logic [IDX_LEN-1:0]              w_wrIdx;
    logic                            w_freeHit;
    logic [IDX_LEN-1:0]              w_freeIdx;
    logic                            w_lkFire;
    logic                            w_wrFire;
    logic                            w_clrLast;
    logic                            w_full;

    assign w_lkFire  = lk_valid & lk_ready;
    assign w_wrFire  = wr_valid & wr_ready;
    assign w_clrLast = (r_clrIdx == IDX_LEN'(NR_KEY - 1));
    assign w_full    = (r_count == CNT_LEN'(NR_KEY));

    assign rsp_valid = r_rspValid;
    assign rsp_hit   = r_rspHit;
    assign rsp_idx   = r_rspIdx;
    assign rsp_data  = r_rspData;
    assign wr_done   = r_wrDone;
    assign wr_ok     = r_wrOk;
    assign count     = r_count;
    assign full      = w_full;

    // Lookup path: sees the table as registered, so a write accepted in the
    // same cycle only becomes visible to later lookups.
    cam_map_match #(
        .NR_KEY     (NR_KEY),
        .KEY_LEN    (KEY_LEN)
    ) u_lkMatch (
        .i_key      (lk_key),
        .i_keys     (r_keys),
        .i_valid    (r_valid),
        .i_anyValid (1'b0),
        .o_hit      (w_lkHit),
        .o_idx      (w_lkIdx)
    );

    // Write path: presence check for UPSERT/DELETE.
    cam_map_match #(
        .NR_KEY     (NR_KEY),
        .KEY_LEN    (KEY_LEN)
    ) u_wrMatch (
        .i_key      (wr_key),
        .i_keys     (r_keys),
        .i_valid    (r_valid),
        .i_anyValid (1'b0),
        .o_hit      (w_wrHit),
        .o_idx      (w_wrIdx)
    );

    // Free-slot search: the same encoder run over the inverted valid bits
    // yields the lowest-index empty entry; no hit means the table is full.
    cam_map_match #(
        .NR_KEY     (NR_KEY),
        .KEY_LEN    (KEY_LEN)
    ) u_freeSlot (
        .i_key      (wr_key),
        .i_keys     (r_keys),
        .i_valid    (~r_valid),
        .i_anyValid (1'b1),
        .o_hit      (w_freeHit),
        .o_idx      (w_freeIdx)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state.  A CLEAR runs for exactly NR_KEY cycles, leaving on
    // the cycle that invalidates the last entry.
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_wrFire && (wr_op == OP_CLEAR)) begin
                    w_stateNext = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (w_clrLast) begin
                    w_stateNext = ST_RUN;
                end
            end
            default: w_stateNext = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs.  The response stage is a single register, so a new
    // lookup may enter whenever the current result leaves in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ready = 1'b0;
        lk_ready = 1'b0;
        if (r_state == ST_RUN) begin
            wr_ready = 1'b1;
            lk_ready = !r_rspValid || rsp_ready;
        end
    end

    // Clear walker: restarts from entry 0 on every CLEAR accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clrIdx <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clrIdx <= w_clrLast ? '0 : r_clrIdx + IDX_LEN'(1);
        end else if (w_wrFire && (wr_op == OP_CLEAR)) begin
            r_clrIdx <= '0;
        end
    end

    // Valid bits, occupancy and write completion.  Every command except
    // CLEAR completes in the accept cycle; CLEAR completes on its last walk
    // cycle, which is also when occupancy drops to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_count  <= '0;
            r_wrDone <= 1'b0;
            r_wrOk   <= 1'b0;
        end else begin
            r_wrDone <= 1'b0;
            r_wrOk   <= 1'b0;
            if (r_state == ST_CLEAR) begin
                r_valid[r_clrIdx] <= 1'b0;
                if (w_clrLast) begin
                    r_count  <= '0;
                    r_wrDone <= 1'b1;
                    r_wrOk   <= 1'b1;
                end
            end else if (w_wrFire) begin
                case (wr_op)
                    OP_NOP: begin
                        r_wrDone <= 1'b1;
                        r_wrOk   <= 1'b1;
                    end
                    OP_UPSERT: begin
                        r_wrDone <= 1'b1;
                        if (w_wrHit) begin
                            r_wrOk <= 1'b1;
                        end else if (w_freeHit) begin
                            r_valid[w_freeIdx] <= 1'b1;
                            r_count            <= r_count + CNT_LEN'(1);
                            r_wrOk             <= 1'b1;
                        end
                    end
                    OP_DELETE: begin
                        r_wrDone <= 1'b1;
                        if (w_wrHit) begin
                            r_valid[w_wrIdx] <= 1'b0;
                            r_count          <= r_count - CNT_LEN'(1);
                            r_wrOk           <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Key/data payload has no reset: an entry is only ever read while its
    // valid bit is set, and that bit is written together with the payload.
    always_ff @(posedge clk) begin
        if (rst_n && w_wrFire && (wr_op == OP_UPSERT)) begin
            if (w_wrHit) begin
                r_data[w_wrIdx] <= wr_data;
            end else if (w_freeHit) begin
                r_keys[w_freeIdx] <= wr_key;
                r_data[w_freeIdx] <= wr_data;
            end
        end
    end

    // Response register: loads on accept, otherwise empties when consumed
    // and holds its fields while back-pressured.  This keeps draining during
    // CLEAR because only acceptance is blocked there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rspValid <= 1'b0;
            r_rspHit   <= 1'b0;
            r_rspIdx   <= '0;
            r_rspData  <= '0;
        end else if (w_lkFire) begin
            r_rspValid <= 1'b1;
            r_rspHit   <= w_lkHit;
            r_rspIdx   <= w_lkHit ? w_lkIdx : '0;
            r_rspData  <= w_lkHit ? r_data[w_lkIdx] : lk_default;
        end else if (rsp_ready) begin
            r_rspValid <= 1'b0;
        end
    end

`ifdef CAM_MAP_STATS_EN
    logic [31:0] r_hitCnt;
    logic [31:0] r_missCnt;

    assign hit_cnt  = r_hitCnt;
    assign miss_cnt = r_missCnt;

    // Lookup statistics, restarted by reset and by a completed CLEAR.
    // Lookups are never accepted during CLEAR, so the two cannot collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hitCnt  <= '0;
            r_missCnt <= '0;
        end else if ((r_state == ST_CLEAR) && w_clrLast) begin
            r_hitCnt  <= '0;
            r_missCnt <= '0;
        end else if (w_lkFire) begin
            if (w_lkHit) begin
                r_hitCnt <= satInc32(r_hitCnt);
            end else begin
                r_missCnt <= satInc32(r_missCnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_map.sv
// ---------------------------------------------------------------------------
// tb_cam_map
//
// Directed bench for cam_map.  A table-level model (arrays of key/data/valid
// plus the response and completion it owes) is advanced on every rising
// edge; a negedge process compares every DUT output against it, and the
// directed sequence adds hand-computed literal expectations.
// Define CAM_MAP_STATS_EN to also cover the statistics counters.
// ---------------------------------------------------------------------------
module tb_cam_map;
    import cam_map_pkg::*;

    localparam int NR_KEY   = 8;
    localparam int KEY_LEN  = 4;
    localparam int DATA_LEN = 8;
    localparam int IDX_LEN  = 3;
    localparam int CNT_LEN  = 4;

    logic                clk;
    logic                rst_n;
    logic                lk_valid;
    logic                lk_ready;
    logic [KEY_LEN-1:0]  lk_key;
    logic [DATA_LEN-1:0] lk_default;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_LEN-1:0] rsp_data;
    logic                rsp_hit;
    logic [IDX_LEN-1:0]  rsp_idx;
    logic                wr_valid;
    logic                wr_ready;
    logic [1:0]          wr_op;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                wr_done;
    logic                wr_ok;
    logic [CNT_LEN-1:0]  count;
    logic                full;
`ifdef CAM_MAP_STATS_EN
    logic [31:0]         hit_cnt;
    logic [31:0]         miss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    cam_map #(
        .NR_KEY     (NR_KEY),
        .KEY_LEN    (KEY_LEN),
        .DATA_LEN   (DATA_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lk_valid   (lk_valid),
        .lk_ready   (lk_ready),
        .lk_key     (lk_key),
        .lk_default (lk_default),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_hit    (rsp_hit),
        .rsp_idx    (rsp_idx),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_op      (wr_op),
        .wr_key     (wr_key),
        .wr_data    (wr_data),
        .wr_done    (wr_done),
        .wr_ok      (wr_ok),
        .count      (count),
        .full       (full)
`ifdef CAM_MAP_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports it when it disagrees.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------
    // Table-level model
    // ------------------------------------------------------------------
    logic [KEY_LEN-1:0]  mKey  [NR_KEY];
    logic [DATA_LEN-1:0] mData [NR_KEY];
    bit                  mValid[NR_KEY];
    int                  mCount;
    bit                  mRspValid;
    bit                  mRspHit;
    int                  mRspIdx;
    logic [DATA_LEN-1:0] mRspData;
    bit                  mDone;
    bit                  mOk;
    int                  mClrLeft;
    bit                  mInit = 1'b0;
    logic [31:0]         mHitCnt;
    logic [31:0]         mMissCnt;

    function automatic int findKey(input logic [KEY_LEN-1:0] k);
        for (int i = 0; i < NR_KEY; i++) begin
            if (mValid[i] && (mKey[i] == k)) return i;
        end
        return -1;
    endfunction

    function automatic int findFree();
        for (int i = 0; i < NR_KEY; i++) begin
            if (!mValid[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        bit lkRdy;
        int f;
        bit newDone;
        bit newOk;
        if (!rst_n) begin
            for (int i = 0; i < NR_KEY; i++) mValid[i] = 1'b0;
            mCount    = 0;
            mRspValid = 1'b0;
            mRspHit   = 1'b0;
            mRspIdx   = 0;
            mRspData  = '0;
            mDone     = 1'b0;
            mOk       = 1'b0;
            mClrLeft  = 0;
            mHitCnt   = '0;
            mMissCnt  = '0;
            mInit     = 1'b1;
        end else if (mInit) begin
            newDone = 1'b0;
            newOk   = 1'b0;
            lkRdy   = (mClrLeft == 0) && (!mRspValid || rsp_ready);
            // Lookup first, so it sees the table before this cycle's write.
            if (lk_valid && lkRdy) begin
                f         = findKey(lk_key);
                mRspValid = 1'b1;
                mRspHit   = (f >= 0);
                mRspIdx   = (f >= 0) ? f : 0;
                mRspData  = (f >= 0) ? mData[f] : lk_default;
                if (f >= 0) begin
                    if (mHitCnt != 32'hFFFF_FFFF) mHitCnt = mHitCnt + 32'd1;
                end else begin
                    if (mMissCnt != 32'hFFFF_FFFF) mMissCnt = mMissCnt + 32'd1;
                end
            end else if (rsp_ready) begin
                mRspValid = 1'b0;
            end
            if (mClrLeft > 0) begin
                mClrLeft--;
                if (mClrLeft == 0) begin
                    for (int i = 0; i < NR_KEY; i++) mValid[i] = 1'b0;
                    mCount   = 0;
                    newDone  = 1'b1;
                    newOk    = 1'b1;
                    mHitCnt  = '0;
                    mMissCnt = '0;
                end
            end else if (wr_valid) begin
                case (wr_op)
                    2'b00: begin
                        newDone = 1'b1;
                        newOk   = 1'b1;
                    end
                    2'b01: begin
                        newDone = 1'b1;
                        f = findKey(wr_key);
                        if (f >= 0) begin
                            mData[f] = wr_data;
                            newOk    = 1'b1;
                        end else begin
                            f = findFree();
                            if (f >= 0) begin
                                mKey[f]   = wr_key;
                                mData[f]  = wr_data;
                                mValid[f] = 1'b1;
                                mCount++;
                                newOk = 1'b1;
                            end
                        end
                    end
                    2'b10: begin
                        newDone = 1'b1;
                        f = findKey(wr_key);
                        if (f >= 0) begin
                            mValid[f] = 1'b0;
                            mCount--;
                            newOk = 1'b1;
                        end
                    end
                    default: mClrLeft = NR_KEY;
                endcase
            end
            mDone = newDone;
            mOk   = newOk;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (mInit) begin
            checkOutput("lk_ready", 32'(lk_ready),
                        32'((mClrLeft == 0) && (!mRspValid || rsp_ready)));
            checkOutput("wr_ready", 32'(wr_ready), 32'(mClrLeft == 0));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(mRspValid));
            if (mRspValid) begin
                checkOutput("rsp_hit", 32'(rsp_hit), 32'(mRspHit));
                checkOutput("rsp_idx", 32'(rsp_idx), 32'(mRspIdx));
                checkOutput("rsp_data", 32'(rsp_data), 32'(mRspData));
            end
            checkOutput("wr_done", 32'(wr_done), 32'(mDone));
            if (mDone) checkOutput("wr_ok", 32'(wr_ok), 32'(mOk));
            checkOutput("count", 32'(count), 32'(mCount));
            checkOutput("full", 32'(full), 32'(mCount == NR_KEY));
`ifdef CAM_MAP_STATS_EN
            checkOutput("hit_cnt", hit_cnt, mHitCnt);
            checkOutput("miss_cnt", miss_cnt, mMissCnt);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: each call drives one cycle and returns 1 time unit
    // after the rising edge that consumed it.
    // ------------------------------------------------------------------
    task automatic applyStimulus(input bit lkV, input logic [KEY_LEN-1:0] lkK,
                                 input logic [DATA_LEN-1:0] lkD, input bit rspR,
                                 input bit wrV, input logic [1:0] op,
                                 input logic [KEY_LEN-1:0] wk,
                                 input logic [DATA_LEN-1:0] wd);
        lk_valid   = lkV;
        lk_key     = lkK;
        lk_default = lkD;
        rsp_ready  = rspR;
        wr_valid   = wrV;
        wr_op      = op;
        wr_key     = wk;
        wr_data    = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 2'b00, '0, '0);
    endtask

    task automatic doWrite(input logic [1:0] op, input logic [KEY_LEN-1:0] k,
                           input logic [DATA_LEN-1:0] d);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, op, k, d);
    endtask

    task automatic doLookup(input logic [KEY_LEN-1:0] k, input logic [DATA_LEN-1:0] dflt);
        applyStimulus(1'b1, k, dflt, 1'b1, 1'b0, 2'b00, '0, '0);
    endtask

    // CLEAR with lookups offered throughout: both ports must stay closed for
    // exactly NR_KEY cycles, then one successful completion pulse.
    task automatic runClear();
        doWrite(OP_CLEAR, '0, '0);
        for (int i = 0; i < NR_KEY; i++) begin
            checkOutput("clr_wr_ready", 32'(wr_ready), 32'd0);
            checkOutput("clr_lk_ready", 32'(lk_ready), 32'd0);
            checkOutput("clr_wr_done", 32'(wr_done), 32'd0);
            applyStimulus(1'b1, 4'd5, 8'h00, 1'b1, 1'b0, 2'b00, '0, '0);
        end
        checkOutput("clr_done", 32'(wr_done), 32'd1);
        checkOutput("clr_ok", 32'(wr_ok), 32'd1);
        checkOutput("clr_count", 32'(count), 32'd0);
        checkOutput("clr_wr_ready_back", 32'(wr_ready), 32'd1);
    endtask

    logic [KEY_LEN-1:0] fillKeys [6];

    initial begin
        fillKeys = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
        rst_n      = 1'b0;
        lk_valid   = 1'b0;
        lk_key     = '0;
        lk_default = '0;
        rsp_ready  = 1'b1;
        wr_valid   = 1'b0;
        wr_op      = 2'b00;
        wr_key     = '0;
        wr_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_hit", 32'(rsp_hit), 32'd0);
        checkOutput("rst_rsp_idx", 32'(rsp_idx), 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_wr_done", 32'(wr_done), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;

        $display("[TB] miss on empty map");
        doLookup(4'd3, 8'hEE);
        checkOutput("miss_valid", 32'(rsp_valid), 32'd1);
        checkOutput("miss_hit", 32'(rsp_hit), 32'd0);
        checkOutput("miss_data", 32'(rsp_data), 32'hEE);
        checkOutput("miss_count", 32'(count), 32'd0);

        $display("[TB] upsert insert and update");
        doWrite(OP_UPSERT, 4'd5, 8'hA1);
        checkOutput("ups1_done", 32'(wr_done), 32'd1);
        checkOutput("ups1_ok", 32'(wr_ok), 32'd1);
        doWrite(OP_UPSERT, 4'd9, 8'hB2);
        checkOutput("ups2_ok", 32'(wr_ok), 32'd1);
        doWrite(OP_UPSERT, 4'd5, 8'hC3);
        checkOutput("ups3_ok", 32'(wr_ok), 32'd1);
        checkOutput("ups_count", 32'(count), 32'd2);
        doLookup(4'd5, 8'h00);
        checkOutput("lk5_hit", 32'(rsp_hit), 32'd1);
        checkOutput("lk5_idx", 32'(rsp_idx), 32'd0);
        checkOutput("lk5_data", 32'(rsp_data), 32'hC3);

        $display("[TB] fill, overflow, delete, reuse slot");
        for (int i = 0; i < 6; i++) doWrite(OP_UPSERT, fillKeys[i], 8'h10 + 8'(i));
        checkOutput("fill_count", 32'(count), 32'd8);
        checkOutput("fill_full", 32'(full), 32'd1);
        doWrite(OP_UPSERT, 4'd15, 8'h5F);
        checkOutput("ovf_done", 32'(wr_done), 32'd1);
        checkOutput("ovf_ok", 32'(wr_ok), 32'd0);
        checkOutput("ovf_count", 32'(count), 32'd8);
        doWrite(OP_DELETE, 4'd0, 8'h00);
        checkOutput("del_ok", 32'(wr_ok), 32'd1);
        checkOutput("del_count", 32'(count), 32'd7);
        checkOutput("del_full", 32'(full), 32'd0);
        doWrite(OP_UPSERT, 4'd15, 8'h5F);
        checkOutput("reuse_ok", 32'(wr_ok), 32'd1);
        doLookup(4'd15, 8'h00);
        checkOutput("reuse_idx", 32'(rsp_idx), 32'd2);
        checkOutput("reuse_data", 32'(rsp_data), 32'h5F);
        doWrite(OP_DELETE, 4'd8, 8'h00);
        checkOutput("del_absent_ok", 32'(wr_ok), 32'd0);
        doWrite(OP_NOP, 4'd0, 8'h00);
        checkOutput("nop_done", 32'(wr_done), 32'd1);
        checkOutput("nop_ok", 32'(wr_ok), 32'd1);

        $display("[TB] clear full table");
        runClear();
        doLookup(4'd15, 8'h77);
        checkOutput("postclr_hit", 32'(rsp_hit), 32'd0);
        checkOutput("postclr_data", 32'(rsp_data), 32'h77);

        $display("[TB] same-cycle lookup and upsert");
        applyStimulus(1'b1, 4'd7, 8'h01, 1'b1, 1'b1, OP_UPSERT, 4'd7, 8'h44);
        checkOutput("rbw_hit", 32'(rsp_hit), 32'd0);
        checkOutput("rbw_data", 32'(rsp_data), 32'h01);
        checkOutput("rbw_wr_ok", 32'(wr_ok), 32'd1);
        doLookup(4'd7, 8'h02);
        checkOutput("rbw_next_hit", 32'(rsp_hit), 32'd1);
        checkOutput("rbw_next_data", 32'(rsp_data), 32'h44);

        $display("[TB] response back-pressure");
        idle(1);
        applyStimulus(1'b1, 4'd7, 8'h03, 1'b0, 1'b0, 2'b00, '0, '0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
            checkOutput("stall_data", 32'(rsp_data), 32'h44);
            checkOutput("stall_lk_ready", 32'(lk_ready), 32'd0);
            applyStimulus(1'b1, 4'd9, 8'h55, 1'b0, 1'b0, 2'b00, '0, '0);
        end
        checkOutput("stall_hold_data", 32'(rsp_data), 32'h44);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 2'b00, '0, '0);
        checkOutput("stall_drained", 32'(rsp_valid), 32'd0);

        $display("[TB] clear with five entries");
        for (int i = 1; i <= 4; i++) doWrite(OP_UPSERT, 4'(i), 8'h20 + 8'(i));
        checkOutput("five_count", 32'(count), 32'd5);
        runClear();
        doLookup(4'd2, 8'h66);
        checkOutput("five_miss_hit", 32'(rsp_hit), 32'd0);
        checkOutput("five_miss_data", 32'(rsp_data), 32'h66);

        $display("[TB] reset during clear");
        doWrite(OP_UPSERT, 4'd10, 8'h21);
        doWrite(OP_UPSERT, 4'd11, 8'h22);
        doLookup(4'd10, 8'h00);
        doLookup(4'd11, 8'h00);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, OP_CLEAR, '0, '0);
        checkOutput("rc_pending", 32'(rsp_valid), 32'd1);
        checkOutput("rc_pending_data", 32'(rsp_data), 32'h22);
        checkOutput("rc_in_clear", 32'(wr_ready), 32'd0);
        idle(1);
        checkOutput("rc_drain", 32'(rsp_valid), 32'd0);
        idle(1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        checkOutput("rc_done", 32'(wr_done), 32'd0);
        checkOutput("rc_count", 32'(count), 32'd0);
        checkOutput("rc_wr_ready", 32'(wr_ready), 32'd1);
        idle(10);
        checkOutput("rc_no_done", 32'(wr_done), 32'd0);

`ifdef CAM_MAP_STATS_EN
        $display("[TB] statistics");
        doWrite(OP_UPSERT, 4'd1, 8'hA0);
        doLookup(4'd1, 8'h00);
        doLookup(4'd1, 8'h00);
        doLookup(4'd2, 8'h00);
        doLookup(4'd3, 8'h00);
        idle(1);
        checkOutput("stat_hit", hit_cnt, 32'd2);
        checkOutput("stat_miss", miss_cnt, 32'd2);
`endif

        doLookup(4'd10, 8'h12);
        checkOutput("postrst_hit", 32'(rsp_hit), 32'd0);
        checkOutput("postrst_data", 32'(rsp_data), 32'h12);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
